// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RV32I data-memory access path.
package riscv_pkg;

  // Access width resolved from the decoder size flags.
  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  // Load/store sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mac_state_e;

  // Major opcodes that reach the load/store unit.
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Byte beats half beats word. With no size flag set, the access is a word.
  function automatic mem_size_e decode_size(input logic one_byte, input logic two_byte);
    if (one_byte) begin
      return SZ_BYTE;
    end
    if (two_byte) begin
      return SZ_HALF;
    end
    return SZ_WORD;
  endfunction

  // Halves need addr[0] clear. Words need both low bits clear.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the load/store sequencer and memory.
// The master drives the request side, and the slave answers with data and ack.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_be_o;
  logic [31:0]       bus_wdata_o;
  logic [31:0]       bus_rdata_i;
  logic              bus_ack_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for sub-word accesses.
// It builds byte enables, replicates store data into every lane, and
// extracts and extends load data.
module mem_lane_align
  import riscv_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  lane,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Select the addressed lane, then build enables, replicated store data and the extended load.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata_raw;
    case (lane)
      2'd0:    byte_val = rdata_raw[7:0];
      2'd1:    byte_val = rdata_raw[15:8];
      2'd2:    byte_val = rdata_raw[23:16];
      default: byte_val = rdata_raw[31:24];
    endcase
    half_val = lane[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~unsigned_ld & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~unsigned_ld & half_val[15]}}, half_val};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the RV32I core.
// It sits between the decoder and a req/ack data bus and stalls the core
// while a transfer is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES.
module mem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              one_byte_i,
  input  logic              two_byte_i,
  input  logic              four_bytes_i,
  input  logic              unsigned_ld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              fault_o,
  mem_access_ctrl_if.master bus
);

  mac_state_e        state, next_state;
  mem_size_e         req_size, size_q;
  logic              req_any, req_misaligned;
  logic              latch_en, capture_en;
  logic [ADDR_W-1:0] addr_q;
  logic              unsigned_q, we_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              timeout_hit, timeout_q;
  logic [3:0]        be;
  logic [31:0]       wdata_rep, rdata_ext;
  logic              busy;

  // A word is already the default size, so four_bytes_i adds no information.
  logic unused_four_bytes;
  assign unused_four_bytes = four_bytes_i;

  assign req_any        = mem_read_i | mem_write_i;
  assign req_size       = decode_size(one_byte_i, two_byte_i);
  assign req_misaligned = is_misaligned(req_size, addr_i[1:0]);
  assign busy           = (state == BUSY);

  // State register. Reset is asynchronous so bus_req_o drops as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the per-cycle control strobes.
  always_comb begin
    next_state = state;
    stall_o    = 1'b0;
    fault_o    = 1'b0;
    done_o     = 1'b0;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (req_misaligned) begin
            fault_o = 1'b1;
          end else begin
            stall_o    = 1'b1;
            latch_en   = 1'b1;
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (bus.bus_ack_i) begin
          capture_en = 1'b1;
          next_state = DONE;
        end else if (timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        fault_o    = timeout_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture the request at acceptance so the bus sees stable values until ack.
  // A read wins when both direction flags are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else if (latch_en) begin
      addr_q     <= addr_i;
      size_q     <= req_size;
      unsigned_q <= unsigned_ld_i;
      we_q       <= ~mem_read_i;
      wdata_q    <= wdata_i;
      rdata_q    <= '0;
    end else if (capture_en) begin
      rdata_q    <= bus.bus_rdata_i;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] busy_cnt;

  assign timeout_hit = busy && !bus.bus_ack_i && (busy_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count BUSY cycles from entry, and remember an abort so DONE can report it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (latch_en) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (busy) begin
      busy_cnt <= busy_cnt + 8'd1;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign timeout_q      = 1'b0;
`endif

  mem_lane_align u_align (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .unsigned_ld (unsigned_q),
    .wdata       (wdata_q),
    .rdata_raw   (rdata_q),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  assign bus.bus_req_o   = busy;
  assign bus.bus_we_o    = busy & we_q;
  assign bus.bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.bus_be_o    = busy ? be : 4'b0000;
  assign bus.bus_wdata_o = (busy && we_q) ? wdata_rep : 32'h0;
  assign rdata_o         = (state == DONE && !we_q && !timeout_q) ? rdata_ext : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Every expected value is written out by hand.
// Build with +define+MEM_TIMEOUT_EN to include the abort case.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, one_byte, two_byte, four_bytes, unsigned_ld;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  int          total = 0;
  int          bad = 0;

  mem_access_ctrl_if #(.ADDR_W(32)) bus_if ();

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .one_byte_i    (one_byte),
    .two_byte_i    (two_byte),
    .four_bytes_i  (four_bytes),
    .unsigned_ld_i (unsigned_ld),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .stall_o       (stall),
    .rdata_o       (rdata),
    .done_o        (done),
    .fault_o       (fault),
    .bus           (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clearRequest();
    mem_read = 0; mem_write = 0; one_byte = 0; two_byte = 0; four_bytes = 0;
    unsigned_ld = 0; addr = 0; wdata = 0;
  endtask

  // Runs one aligned access. The call starts just after a falling edge.
  // busy_cycles is the number of BUSY cycles, and ack arrives in the last one.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic ob, input logic hb, input logic wb,
                               input logic uns, input logic [31:0] a,
                               input logic [31:0] wd, input int busy_cycles,
                               input logic [31:0] bus_data, input logic [3:0] exp_be,
                               input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    int stall_cnt = 0;
    mem_read = rd; mem_write = wr; one_byte = ob; two_byte = hb; four_bytes = wb;
    unsigned_ld = uns; addr = a; wdata = wd;
    #1;
    checkOutput({tag, "/req_stall"}, {31'd0, stall}, 32'd1);
    if (stall) stall_cnt++;
    for (int k = 0; k < busy_cycles; k++) begin
      @(negedge clk);
      if (k == busy_cycles - 1) begin
        bus_if.bus_ack_i = 1'b1;
        bus_if.bus_rdata_i = bus_data;
      end
      #1;
      if (stall) stall_cnt++;
      if (k == 0) begin
        checkOutput({tag, "/bus_req"}, {31'd0, bus_if.bus_req_o}, 32'd1);
        checkOutput({tag, "/bus_be"}, {28'd0, bus_if.bus_be_o}, {28'd0, exp_be});
        checkOutput({tag, "/bus_addr"}, bus_if.bus_addr_o, a & 32'hFFFF_FFFC);
        checkOutput({tag, "/bus_we"}, {31'd0, bus_if.bus_we_o}, {31'd0, wr & ~rd});
        checkOutput({tag, "/bus_wdata"}, bus_if.bus_wdata_o, exp_wd);
      end
    end
    @(negedge clk);
    bus_if.bus_ack_i = 1'b0;
    bus_if.bus_rdata_i = 32'h0;
    #1;
    checkOutput({tag, "/done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "/done_stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, "/done_req"}, {31'd0, bus_if.bus_req_o}, 32'd0);
    checkOutput({tag, "/rdata"}, rdata, exp_rd);
    checkOutput({tag, "/stall_cycles"}, stall_cnt, 1 + busy_cycles);
    clearRequest();
    @(negedge clk);
    #1;
    checkOutput({tag, "/done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Sends a misaligned request. The fault should pulse with no bus cycle and no stall.
  task automatic applyMisaligned(input string tag, input logic hb, input logic [31:0] a);
    mem_read = 1; one_byte = 0; two_byte = hb; four_bytes = ~hb; addr = a;
    #1;
    checkOutput({tag, "/fault"}, {31'd0, fault}, 32'd1);
    checkOutput({tag, "/stall"}, {31'd0, stall}, 32'd0);
    clearRequest();
    @(negedge clk);
    #1;
    checkOutput({tag, "/no_req"}, {31'd0, bus_if.bus_req_o}, 32'd0);
    checkOutput({tag, "/fault_pulse"}, {31'd0, fault}, 32'd0);
    checkOutput({tag, "/no_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clearRequest();
    bus_if.bus_ack_i = 1'b0;
    bus_if.bus_rdata_i = 32'h0;
    #1;
    checkOutput("rst/stall", {31'd0, stall}, 32'd0);
    checkOutput("rst/done", {31'd0, done}, 32'd0);
    checkOutput("rst/fault", {31'd0, fault}, 32'd0);
    checkOutput("rst/rdata", rdata, 32'h0);
    checkOutput("rst/req", {31'd0, bus_if.bus_req_o}, 32'd0);
    checkOutput("rst/addr", bus_if.bus_addr_o, 32'h0);
    checkOutput("rst/be", {28'd0, bus_if.bus_be_o}, 32'd0);
    checkOutput("rst/wdata", bus_if.bus_wdata_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //              tag    rd wr ob hb wb uns addr          wdata         n  bus data      be       bus wdata     rdata_o
    applyStimulus("lw",   1, 0, 0, 0, 1, 0, 32'h0000_0100, 32'h0,        2, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF);
    applyStimulus("lb",   1, 0, 1, 0, 0, 0, 32'h0000_0103, 32'h0,        1, 32'h80000000, 4'b1000, 32'h0,        32'hFFFFFF80);
    applyStimulus("lbu",  1, 0, 1, 0, 0, 1, 32'h0000_0103, 32'h0,        1, 32'h80000000, 4'b1000, 32'h0,        32'h00000080);
    applyStimulus("lh",   1, 0, 0, 1, 0, 0, 32'h0000_0100, 32'h0,        1, 32'h0000F00F, 4'b0011, 32'h0,        32'hFFFFF00F);
    applyStimulus("lhu",  1, 0, 0, 1, 0, 1, 32'h0000_0102, 32'h0,        3, 32'h12345678, 4'b1100, 32'h0,        32'h00001234);
    applyStimulus("sh",   0, 1, 0, 1, 0, 0, 32'h0000_0102, 32'h0000ABCD, 1, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0);
    applyStimulus("sb",   0, 1, 1, 0, 0, 0, 32'h0000_0101, 32'h000000A5, 2, 32'hFFFFFFFF, 4'b0010, 32'hA5A5A5A5, 32'h0);
    applyStimulus("sw",   0, 1, 0, 0, 1, 0, 32'h0000_0104, 32'h11223344, 1, 32'h0,        4'b1111, 32'h11223344, 32'h0);
    applyStimulus("lw_nosz", 1, 0, 0, 0, 0, 0, 32'h0000_010C, 32'h0,     1, 32'hCAFEF00D, 4'b1111, 32'h0,        32'hCAFEF00D);
    applyStimulus("rd_wins", 1, 1, 0, 0, 1, 0, 32'h0000_0108, 32'h55555555, 1, 32'h01020304, 4'b1111, 32'h0,    32'h01020304);

    applyMisaligned("mis_lw", 1'b0, 32'h0000_0101);
    applyMisaligned("mis_lh", 1'b1, 32'h0000_0103);

    // Reset during BUSY: the request drops at once, and a later ack is ignored.
    mem_read = 1; four_bytes = 1; addr = 32'h0000_0200;
    @(negedge clk);
    #1;
    checkOutput("rstmid/busy_req", {31'd0, bus_if.bus_req_o}, 32'd1);
    rst_n = 1'b0;
    clearRequest();
    #1;
    checkOutput("rstmid/req_drop", {31'd0, bus_if.bus_req_o}, 32'd0);
    checkOutput("rstmid/stall", {31'd0, stall}, 32'd0);
    bus_if.bus_ack_i = 1'b1;
    bus_if.bus_rdata_i = 32'h87654321;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rstmid/no_done", {31'd0, done}, 32'd0);
    checkOutput("rstmid/no_req", {31'd0, bus_if.bus_req_o}, 32'd0);
    bus_if.bus_ack_i = 1'b0;
    bus_if.bus_rdata_i = 32'h0;
    @(negedge clk);
    #1;
    checkOutput("rstmid/still_no_done", {31'd0, done}, 32'd0);
    checkOutput("rstmid/rdata", rdata, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // Abort case: no ack ever arrives, so the access should give up after 4 BUSY cycles.
    begin
      int busy_seen = 0;
      int guard = 0;
      bus_if.bus_rdata_i = 32'hFFFFFFFF;
      mem_read = 1; four_bytes = 1; addr = 32'h0000_0300;
      while (guard < 20) begin
        @(negedge clk);
        #1;
        guard++;
        if (done) break;
        if (bus_if.bus_req_o) busy_seen++;
      end
      checkOutput("tmo/done", {31'd0, done}, 32'd1);
      checkOutput("tmo/fault", {31'd0, fault}, 32'd1);
      checkOutput("tmo/rdata", rdata, 32'h0);
      checkOutput("tmo/busy_cycles", busy_seen, 32'd4);
      checkOutput("tmo/req", {31'd0, bus_if.bus_req_o}, 32'd0);
      clearRequest();
      bus_if.bus_rdata_i = 32'h0;
      @(negedge clk);
      #1;
      checkOutput("tmo/fault_pulse", {31'd0, fault}, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
